// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment / 74HC595 display driver:
// hex-to-segment table, serialiser state encoding and frame-width helper.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } frame_state_t;

    // Lit segments for hex 0..F, bit order gfedcba (bit 0 = segment a), active high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // One select line per digit plus eight segment lines (dp included).
    function automatic int frame_width(input int digits);
        return digits + 8;
    endfunction

endpackage

// File: rtl/hc595_shifter.sv
// Generic N-bit serialiser for a 74HC595 chain: MSB first on ds, clocked by
// shcp, followed by one stcp pulse that moves the frame to the output latches.
module hc595_shifter
    import seg_pkg::*;
#(
    parameter int N         = 14,
    parameter int SHIFT_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] frame,
    output logic         shcp,
    output logic         ds,
    output logic         stcp
);

    localparam int DIV_W = $clog2(2 * SHIFT_DIV);
    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(SHIFT_DIV - 1);
    localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(2 * SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

    frame_state_t     state;
    // The MSB goes straight to ds on LOAD, so only the remaining bits are held here.
    logic [N-2:0]     shreg;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shcp    <= 1'b0;
            ds      <= 1'b0;
            stcp    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg   <= frame[N-2:0];
                    ds      <= frame[N-1];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    shcp    <= 1'b0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt == HALF_END) begin
                        shcp    <= 1'b1;
                        div_cnt <= div_cnt + 1'b1;
                    end else if (div_cnt == BIT_END) begin
                        // Falling shcp edge: ds moves only here, so it is stable across the rise.
                        shcp    <= 1'b0;
                        div_cnt <= '0;
                        ds      <= shreg[N-2];
                        shreg   <= shreg << 1;
                        if (bit_cnt == LAST_BIT) begin
                            stcp  <= 1'b1;
                            state <= ST_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == HALF_END) begin
                        stcp    <= 1'b0;
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg_595_dynamic.sv
// Multiplexed multi-digit hex display: scans one digit per SCAN_CYC cycles and
// ships each select/segment frame to a 74HC595 chain through hc595_shifter.
module seg_595_dynamic
    import seg_pkg::*;
#(
    parameter int DIGITS          = 6,
    parameter int SCAN_CYC        = 50000,
    parameter int SHIFT_DIV       = 2,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  en,
    output logic                  stcp,
    output logic                  shcp,
    output logic                  ds,
    output logic                  oe
);

    localparam int N       = frame_width(DIGITS);
    localparam int TIMER_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCAN_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [TIMER_W-1:0] scan_timer;
    logic [IDX_W-1:0]   digit_idx;
    logic [3:0]         nibble [DIGITS];
    logic [DIGITS-1:0]  sel_on;
    logic [DIGITS-1:0]  sel;
    logic [7:0]         seg_on;
    logic [7:0]         seg;
    logic [N-1:0]       frame;
    logic               start;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_timer <= '0;
            digit_idx  <= '0;
        end else if (scan_timer == TIMER_LAST) begin
            scan_timer <= '0;
            digit_idx  <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_timer <= scan_timer + 1'b1;
        end
    end

    // Output enable follows en with one register stage; scanning never pauses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            oe <= 1'b1;
        end else begin
            oe <= ~en;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi] = data[4*gi +: 4];
            assign sel_on[gi] = (digit_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        seg_on = {point[digit_idx], HEX_SEG[nibble[digit_idx]]};
        if (blank[digit_idx]) begin
            seg_on = 8'h00;
        end
        seg = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        sel = (SEL_ACTIVE_HIGH != 0) ? sel_on : ~sel_on;
    end

    assign frame = {sel, seg};
    assign start = (scan_timer == '0);

    hc595_shifter #(
        .N         (N),
        .SHIFT_DIV (SHIFT_DIV)
    ) u_shifter (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (start),
        .frame (frame),
        .shcp  (shcp),
        .ds    (ds),
        .stcp  (stcp)
    );

endmodule

// File: tb/tb_seg_595_dynamic.sv
// Bench for seg_595_dynamic: a monitor rebuilds each latched 595 frame from
// shcp/ds/stcp and checks it against frames queued by the directed stimulus.
module tb_seg_595_dynamic;

    localparam int DIGITS    = 6;
    localparam int SCAN_CYC  = 200;
    localparam int SHIFT_DIV = 2;
    localparam int N         = DIGITS + 8;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [4*DIGITS-1:0] data = '0;
    logic [DIGITS-1:0]   point = '0;
    logic [DIGITS-1:0]   blank = '0;
    logic                en = 1'b1;
    logic                stcp;
    logic                shcp;
    logic                ds;
    logic                oe;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] exp_q [$];

    seg_595_dynamic #(
        .DIGITS          (DIGITS),
        .SCAN_CYC        (SCAN_CYC),
        .SHIFT_DIV       (SHIFT_DIV),
        .SEG_ACTIVE_LOW  (1),
        .SEL_ACTIVE_HIGH (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .blank     (blank),
        .en        (en),
        .stcp      (stcp),
        .shcp      (shcp),
        .ds        (ds),
        .oe        (oe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        wait_cyc(3);
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: shift in ds on each shcp rise, compare on each stcp rise.
    logic         mon_prev_shcp = 1'b0;
    logic         mon_prev_stcp = 1'b0;
    logic         mon_prev_ds = 1'b0;
    logic         mon_ds_moved = 1'b0;
    logic [N-1:0] mon_cap = '0;
    logic [N-1:0] mon_exp = '0;
    int           mon_bits = 0;
    int           mon_frames = 0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                mon_prev_shcp = 1'b0;
                mon_prev_stcp = 1'b0;
                mon_prev_ds   = 1'b0;
                mon_ds_moved  = 1'b0;
                mon_cap       = '0;
                mon_bits      = 0;
            end else begin
                if (shcp && !mon_prev_shcp) begin
                    mon_cap = {mon_cap[N-2:0], ds};
                    mon_bits++;
                end
                if (shcp && mon_prev_shcp && (ds != mon_prev_ds)) begin
                    mon_ds_moved = 1'b1;
                end
                if (stcp && !mon_prev_stcp) begin
                    mon_frames++;
                    $display("frame %0d: sel=%b seg=%h bits=%0d", mon_frames,
                             mon_cap[N-1:8], mon_cap[7:0], mon_bits);
                    check("frame_bits", 32'(mon_bits), 32'(N));
                    check("ds_stable_while_shcp_high", 32'(mon_ds_moved), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(mon_cap), 32'h0);
                        if (mon_cap == '0) begin
                            failures++;
                            $display("FAIL unexpected_frame got=%h expected=none", mon_cap);
                        end
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("frame_value", 32'(mon_cap), 32'(mon_exp));
                    end
                    mon_bits     = 0;
                    mon_ds_moved = 1'b0;
                end
                mon_prev_shcp = shcp;
                mon_prev_stcp = stcp;
                mon_prev_ds   = ds;
            end
        end
    end

    initial begin
        int cyc;
        int rises;
        logic prev;

        // Reset values while sys_rst_n is held low.
        wait_cyc(3);
        check("reset_outputs_stcp_shcp_ds_oe", 32'({stcp, shcp, ds, oe}), 32'b0001);

        // Phase 1: data 123456, full scan plus wrap, en toggled mid-scan.
        data = 24'h123456;
        exp_q.push_back({6'b000001, 8'h82});
        exp_q.push_back({6'b000010, 8'h92});
        exp_q.push_back({6'b000100, 8'h99});
        exp_q.push_back({6'b001000, 8'hB0});
        exp_q.push_back({6'b010000, 8'hA4});
        exp_q.push_back({6'b100000, 8'hF9});
        exp_q.push_back({6'b000001, 8'h82});
        release_reset();
        // Start pulse in cycle 0, LOAD in cycle 1, shcp low cycles 2-3, high from cycle 4.
        cyc = 0;
        while (!shcp && cyc < 10) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("first_shcp_rise_cycle", 32'(cyc), 32'd4);
        wait_cyc(296);
        en = 1'b0;
        #1;
        check("oe_before_edge_after_en_fall", 32'(oe), 32'd0);
        @(negedge sys_clk);
        check("oe_after_en_fall", 32'(oe), 32'd1);
        wait_cyc(100);
        en = 1'b1;
        #1;
        check("oe_before_edge_after_en_rise", 32'(oe), 32'd1);
        @(negedge sys_clk);
        check("oe_after_en_rise", 32'(oe), 32'd0);
        wait_cyc(918);
        check_drained("phase1_frames_seen");

        // Phase 2: decimal point on digit 2, digit 5 blanked.
        apply_reset();
        data  = 24'hFEDCBA;
        point = 6'b000100;
        blank = 6'b100000;
        exp_q.push_back({6'b000001, 8'h88});
        exp_q.push_back({6'b000010, 8'h83});
        exp_q.push_back({6'b000100, 8'h46});
        exp_q.push_back({6'b001000, 8'hA1});
        exp_q.push_back({6'b010000, 8'h86});
        exp_q.push_back({6'b100000, 8'hFF});
        release_reset();
        wait_cyc(5 * SCAN_CYC + 120);
        check_drained("phase2_frames_seen");

        // Phase 3: data changes while frame 0 is shifting.
        apply_reset();
        data  = 24'h000000;
        point = '0;
        blank = '0;
        exp_q.push_back({6'b000001, 8'hC0});
        exp_q.push_back({6'b000010, 8'h92});
        exp_q.push_back({6'b000100, 8'h82});
        exp_q.push_back({6'b001000, 8'hF8});
        exp_q.push_back({6'b010000, 8'h80});
        exp_q.push_back({6'b100000, 8'h90});
        exp_q.push_back({6'b000001, 8'h99});
        release_reset();
        wait_cyc(20);
        data = 24'h987654;
        wait_cyc(6 * SCAN_CYC + 100);
        check_drained("phase3_frames_seen");

        // Phase 4: reset at the 7th shcp rise, then a fresh frame for digit 0.
        apply_reset();
        data = 24'h00000E;
        release_reset();
        rises = 0;
        cyc   = 0;
        prev  = 1'b0;
        while (rises < 7 && cyc < 100) begin
            @(negedge sys_clk);
            cyc++;
            if (shcp && !prev) rises++;
            prev = shcp;
        end
        check("seventh_shcp_rise_reached", 32'(rises), 32'd7);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({stcp, shcp, ds, oe}), 32'b0001);
        wait_cyc(3);
        exp_q.push_back({6'b000001, 8'h86});
        release_reset();
        wait_cyc(120);
        check_drained("phase4_frames_seen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_595_dynamic.md
Name: seg_595_dynamic

Overview:
- Parametrised multi-digit 7-segment display driver with a built-in serial front end for a chain of 74HC595 shift registers.
- Time-multiplexes DIGITS digits of hex data, with per-digit decimal point and blanking, at a programmable scan rate.
- Each digit's select/segment frame is shifted out serially via shcp/ds, then latched with stcp.
- Replaces the static display plus separate 595 controller pairing; sits directly at the board pins.

Parameters:
- DIGITS, 6: number of digits; frame width N = DIGITS+8.
- SCAN_CYC, 50000: sys_clk cycles each digit stays selected (≥ 4*SHIFT_DIV*N).
- SHIFT_DIV, 2: sys_clk cycles per shcp half-period (≥1).
- SEG_ACTIVE_LOW, 1: 1 = segment lines driven low to light (common anode).
- SEL_ACTIVE_HIGH, 1: 1 = selected digit line driven high.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- data  in  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i], digit 0 rightmost
- point  in  DIGITS  decimal point on for digit i
- blank  in  DIGITS  digit i dark (segments all off) when 1
- en  in  1  display enable
- stcp  out  1  595 storage clock
- shcp  out  1  595 shift clock
- ds  out  1  595 serial data
- oe  out  1  595 output enable, active low

Behaviour:
- Clocking and reset: one clock (sys_clk); reset asynchronous, active-low (sys_rst_n).
- Reset values:
  - stcp=0, shcp=0, ds=0, oe=1.
  - Digit index=0, scan timer=0, shift engine IDLE.
- oe: registered; oe = ~en one cycle after en changes. Scanning and shifting continue regardless of en.
- Scan timer: counts 0..SCAN_CYC-1 and wraps. On wrap, the digit index increments, wrapping DIGITS-1 -> 0.
- Decode:
  - Hex 0-F maps to the standard gfedcba pattern (A,b,C,d,E,F for 10-15); seg[7] = dp.
  - Blank forces all segments and dp off.
  - Polarity is applied last per SEG_ACTIVE_LOW.
  - sel is one-hot of the digit index, polarity per SEL_ACTIVE_HIGH.
- Frame: F = {sel[DIGITS-1:0], seg[7:0]}, N bits. Bit N-1 is shifted first; seg[0] is shifted last.
- Shift engine FSM: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
  - IDLE: waits for a one-cycle start pulse, issued when the scan timer equals 0 (includes the first cycle after reset).
  - LOAD (1 cycle): snapshots F. Later changes to data/point/blank do not affect the frame in flight.
  - SHIFT, per bit (2*SHIFT_DIV cycles):
    - ds updated while shcp is low.
    - shcp held low SHIFT_DIV cycles, then high SHIFT_DIV cycles.
    - ds stable across the rising edge.
    - After N bits, shcp returns low.
  - LATCH: stcp high for SHIFT_DIV cycles, then low; return to IDLE.
- Frame duration: 1 + 2*SHIFT_DIV*N + SHIFT_DIV cycles. Frame k (digit k) is latched well before the next scan wrap.
- A start pulse arriving while not in IDLE is ignored; it cannot occur when the SCAN_CYC constraint holds.
- Reset mid-frame: all outputs go to reset values immediately; no partial stcp pulse.
- All outputs are registered; no combinational path from inputs to pins.

Decomposition:
- Package seg_pkg: hex-to-7-segment constant table (16×7), frame-state enum, and an N-width helper function.
- One sub-module, hc595_shifter:
  - Generic N-bit serialiser with start input, SHIFT_DIV timing, and shcp/ds/stcp outputs.
  - Reusable for LED bars.
- Scan timer, digit mux and decode stay in the top module.

Test Plan:
- Reset release with DIGITS=6, SHIFT_DIV=2, SCAN_CYC=200, data=0x123456, point=0, blank=0, en=1:
  - First frame starts within 2 cycles; 14 shcp rising edges then one stcp pulse.
  - Captured frame = sel 000001, seg 0x82 (digit '6', active low).
- Full scan: over 6×SCAN_CYC cycles, latched sel steps 000001, 000010 … 100000, then wraps to 000001. Segments match digits 6,5,4,3,2,1.
- point=6'b000100, blank=6'b100000:
  - Digit 2 frame has seg[7]=0 (dp lit).
  - Digit 5 frame has seg=0xFF with its sel bit still asserted.
- Change data mid-SHIFT: the in-flight frame holds the old value; the next frame for that digit shows the new one.
- Toggle en: oe goes 1 one cycle after en falls and 0 one cycle after en rises; shcp/stcp activity is unaffected.
- Assert sys_rst_n=0 at the 7th shcp edge of a frame: outputs go to reset values asynchronously. After release, a full fresh 14-bit frame for digit 0 is sent.
